data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Word-addressed synchronous data memory with a configurable wait-state controller. It sits directly downstream of the memory-control stage and consumes its access request (`ADD_selector`, `RW`, `ADD_bus`, `DataBus_out`). It returns load data on `DataBus_in` and holds the pipeline with `Stall` until the access completes. The storage array is internal. Out-of-range addresses are trapped and flagged rather than aliased.

## Interface
- `DEPTH`, 1024: number of 32-bit words; legal word addresses are 0..`DEPTH`-1 (`DEPTH` ≤ 65536).
- `WAIT_STATES`, 2: extra cycles per access, range 0..15.

- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  reset: one clock, synchronous, active-high.
- `ADD_selector`  in  1  access request; level-sensitive; sampled only in IDLE.
- `RW`  in  1  access direction: 1 = write (STR), 0 = read (LDR).
- `ADD_bus`  in  16  word address.
- `DataBus_out`  in  32  store data.
- `DataBus_in`  out  32  load data; registered; holds the last completed read.
- `Stall`  out  1  combinational; high while an access is pending.
- `Done`  out  1  registered; one-cycle pulse in the completion cycle.
- `Addr_error`  out  1  registered; pulses with `Done` when the address was ≥ `DEPTH`.

## Operation
- States: IDLE, WAIT, COMPLETE. A 4-bit wait counter is used in WAIT.
- IDLE, `ADD_selector`=1 at an edge:
  - Latch `ADD_bus`, `DataBus_out` and `RW`, and compute the range check.
  - `WAIT_STATES`>0: go to WAIT and load the counter with `WAIT_STATES`.
  - `WAIT_STATES`=0: go directly to COMPLETE.
- WAIT:
  - Decrement the counter each edge.
  - At the edge where the counter is 1, go to COMPLETE.
  - Inputs are ignored; the latched values are used.
- Array access happens on the edge that enters COMPLETE.
  - Source values: the inputs when entering from IDLE, the latched values when entering from WAIT.
  - Write, in range: `mem[addr]` ← data; `DataBus_in` is unchanged.
  - Read, in range: `DataBus_in` ← `mem[addr]`.
  - Out of range: no array write. A read loads `DataBus_in` with 0. `Addr_error` ← 1.
- COMPLETE: `Done`=1 and `Stall`=0. The next edge always returns to IDLE.
  - If `ADD_selector` is still high in IDLE, a new access starts. Back-to-back accesses are legal.
- `Stall` = (`state`==IDLE & `ADD_selector`) | (`state`==WAIT).
- `RST`:
  - Forces IDLE and clears the counter.
  - Output reset values: `DataBus_in`=0, `Done`=0, `Addr_error`=0.
  - `Stall` follows its equation, so it reads 0 in IDLE with no request.
  - Array contents are not cleared; an unwritten word reads as undefined.
- Reset mid-access (in WAIT): the access is aborted, no array write occurs, `DataBus_in` reads 0.
- `RST` has priority over any request in the same cycle.

## Timing
- Request sampled at edge E0. `Stall` is high for `WAIT_STATES`+1 cycles: the IDLE request cycle plus the WAIT cycles.
- `Done` and `Addr_error` are high in the single cycle following edge E0+`WAIT_STATES`.
- `DataBus_in` is valid in the same cycle as `Done` and holds until the next completed read or `RST`.
- Write data is visible to a read whose array access falls at the next edge or later; there is no same-edge read/write conflict, since one access is in flight at a time.
- Throughput: one access per `WAIT_STATES`+2 cycles with the request held continuously.
- `Done` is never high in two consecutive cycles.

## Test plan
- `WAIT_STATES`=2, write `ADD_bus`=0x0010, data 0xDEADBEEF, then read 0x0010:
  - `Stall` is high for 3 cycles on each access.
  - The read's `Done` cycle shows `DataBus_in`=0xDEADBEEF.
  - `Addr_error`=0 throughout.
- `WAIT_STATES`=0: read 0x0010 → `Stall` is high for 1 cycle and `Done` rises the cycle after the request with `DataBus_in`=0xDEADBEEF.
- `DEPTH`=1024:
  - Write 0x0400 with data 0x12345678 → `Done` and `Addr_error` pulse together.
  - A following read of 0x0000 returns its prior value, proving no alias.
  - A read of 0xFFFF returns 0 with `Addr_error`=1.
- Write 0x0020 with data 0xA5A5A5A5, then assert `RST` during the second WAIT cycle:
  - Outputs go to their reset values, with no `Done`.
  - A later read of 0x0020 must not return 0xA5A5A5A5; preload it with 0x11111111 first, and the read returns 0x11111111.
- Hold `ADD_selector`=1 with `RW`=0 over addresses 1, 2 and 3, changing the address during WAIT:
  - The latched address is used for each access.
  - `Done` pulses every `WAIT_STATES`+2 cycles.
  - `DataBus_in` steps through the stored values in order.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - word-addressed data memory with wait-state controller and range trap
module data_memory_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ADD_selector,
    input  logic        RW,
    input  logic [15:0] ADD_bus,
    input  logic [31:0] DataBus_out,
    output logic [31:0] DataBus_in,
    output logic        Stall,
    output logic        Done,
    output logic        Addr_error
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        rw_q, rw_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [31:0] mem [0:DEPTH-1];

    logic        acc_en;
    logic        acc_rw;
    logic [15:0] acc_addr;
    logic [31:0] acc_data;
    logic        in_range;
    logic [31:0] mem_rd;
    logic        mem_we;

    // Select the access source: live inputs on a zero-wait entry, latched request otherwise
    always_comb begin
        acc_en   = 1'b0;
        acc_rw   = rw_q;
        acc_addr = addr_q;
        acc_data = data_q;
        if (state_q == IDLE && ADD_selector && WAIT_STATES == 0) begin
            acc_en   = 1'b1;
            acc_rw   = RW;
            acc_addr = ADD_bus;
            acc_data = DataBus_out;
        end else if (state_q == WAIT && cnt_q == 4'd1) begin
            acc_en = 1'b1;
        end
    end

    assign in_range = ({1'b0, acc_addr} < 17'(DEPTH));
    assign mem_rd   = mem[acc_addr[AW-1:0]];
    assign mem_we   = acc_en && acc_rw && in_range && !RST;

    // Next-state, request latch and completion outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ADD_selector) begin
                    addr_d = ADD_bus;
                    data_d = DataBus_out;
                    rw_d   = RW;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = COMPLETE;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (acc_en) begin
            done_d = 1'b1;
            err_d  = !in_range;
            if (!acc_rw) begin
                rdata_d = in_range ? mem_rd : 32'd0;
            end
        end
    end

    // Controller registers; reset aborts any pending access
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'd0;
            data_q  <= 32'd0;
            rw_q    <= 1'b0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage array write port; contents survive reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[acc_addr[AW-1:0]] <= acc_data;
        end
    end

    assign Stall      = (state_q == IDLE && ADD_selector) || (state_q == WAIT);
    assign Done       = done_q;
    assign Addr_error = err_q;
    assign DataBus_in = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel2 = 1'b0;
    logic        sel0 = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;

    logic [31:0] rd2, rd0;
    logic        stall2, stall0, done2, done0, err2, err0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
        .CLK(clk), .RST(rst), .ADD_selector(sel2), .RW(rw), .ADD_bus(addr),
        .DataBus_out(wdata), .DataBus_in(rd2), .Stall(stall2), .Done(done2),
        .Addr_error(err2)
    );

    data_memory_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .CLK(clk), .RST(rst), .ADD_selector(sel0), .RW(rw), .ADD_bus(addr),
        .DataBus_out(wdata), .DataBus_in(rd0), .Stall(stall0), .Done(done0),
        .Addr_error(err0)
    );

    // One access on instance b (0 = WAIT_STATES 2, 1 = WAIT_STATES 0); entered and left at a negedge
    task automatic access(input bit b, input bit w, input logic [15:0] a, input logic [31:0] d,
                          output int stalls, output int lat, output logic [31:0] rd,
                          output logic er);
        rw = w; addr = a; wdata = d;
        if (b) sel0 = 1'b1; else sel2 = 1'b1;
        stalls = 0; lat = 0; rd = 'x; er = 1'bx;
        #1;
        if (b ? stall0 : stall2) stalls++;
        @(negedge clk);
        sel0 = 1'b0; sel2 = 1'b0;
        lat = 1;
        while (lat < 30) begin
            if (b ? done0 : done2) begin
                rd = b ? rd0 : rd2;
                er = b ? err0 : err2;
                break;
            end
            if (b ? stall0 : stall2) stalls++;
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        tests++; if (rd2 !== 32'd0)  begin fails++; $display("FAIL reset_data got %h exp 0", rd2); end
        tests++; if (done2 !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done2); end
        tests++; if (err2 !== 1'b0)  begin fails++; $display("FAIL reset_err got %b exp 0", err2); end
        tests++; if (stall2 !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall2); end
        tests++; if (rd0 !== 32'd0 || done0 !== 1'b0) begin
            fails++; $display("FAIL reset_ws0 got data %h done %b exp 0 0", rd0, done0);
        end
    endtask

    task automatic test_write_read;
        int s, l; logic [31:0] r; logic e;
        access(0, 1, 16'h0010, 32'hDEADBEEF, s, l, r, e);
        tests++; if (s != 3) begin fails++; $display("FAIL wr_stall got %0d exp 3", s); end
        tests++; if (l != 3) begin fails++; $display("FAIL wr_latency got %0d exp 3", l); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL wr_err got %b exp 0", e); end
        access(0, 0, 16'h0010, 32'h0, s, l, r, e);
        tests++; if (s != 3) begin fails++; $display("FAIL rd_stall got %0d exp 3", s); end
        tests++; if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h exp deadbeef", r); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL rd_err got %b exp 0", e); end
    endtask

    task automatic test_zero_wait;
        int s, l; logic [31:0] r; logic e;
        access(1, 1, 16'h0010, 32'hDEADBEEF, s, l, r, e);
        access(1, 0, 16'h0010, 32'h0, s, l, r, e);
        tests++; if (s != 1) begin fails++; $display("FAIL zw_stall got %0d exp 1", s); end
        tests++; if (l != 1) begin fails++; $display("FAIL zw_latency got %0d exp 1", l); end
        tests++; if (r !== 32'hDEADBEEF) begin fails++; $display("FAIL zw_data got %h exp deadbeef", r); end
    endtask

    task automatic test_addr_error;
        int s, l; logic [31:0] r; logic e;
        access(0, 1, 16'h0000, 32'hCAFEF00D, s, l, r, e);
        access(0, 1, 16'h0400, 32'h12345678, s, l, r, e);
        tests++; if (l != 3 || e !== 1'b1) begin
            fails++; $display("FAIL oor_write got lat %0d err %b exp 3 1", l, e);
        end
        access(0, 0, 16'h0000, 32'h0, s, l, r, e);
        tests++; if (r !== 32'hCAFEF00D || e !== 1'b0) begin
            fails++; $display("FAIL no_alias got %h err %b exp cafef00d 0", r, e);
        end
        access(0, 0, 16'hFFFF, 32'h0, s, l, r, e);
        tests++; if (r !== 32'd0 || e !== 1'b1) begin
            fails++; $display("FAIL oor_read got %h err %b exp 0 1", r, e);
        end
    endtask

    task automatic test_reset_mid;
        int s, l; logic [31:0] r; logic e;
        access(0, 1, 16'h0020, 32'h11111111, s, l, r, e);
        access(0, 0, 16'h0020, 32'h0, s, l, r, e);
        rw = 1'b1; addr = 16'h0020; wdata = 32'hA5A5A5A5; sel2 = 1'b1;
        @(negedge clk);
        sel2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++; if (done2 !== 1'b0 || rd2 !== 32'd0 || err2 !== 1'b0 || stall2 !== 1'b0) begin
            fails++; $display("FAIL mid_reset got done %b data %h err %b stall %b exp 0 0 0 0",
                              done2, rd2, err2, stall2);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (done2 !== 1'b0) begin fails++; $display("FAIL mid_reset_nodone got %b exp 0", done2); end
        access(0, 0, 16'h0020, 32'h0, s, l, r, e);
        tests++; if (r !== 32'h11111111) begin fails++; $display("FAIL aborted_write got %h exp 11111111", r); end
    endtask

    task automatic test_back_to_back;
        int s, l; logic [31:0] r; logic e;
        logic [31:0] vals [0:3];
        vals[0] = 32'h0; vals[1] = 32'h0000AAA1; vals[2] = 32'h0000BBB2; vals[3] = 32'h0000CCC3;
        for (int k = 1; k <= 3; k++) access(0, 1, 16'(k), vals[k], s, l, r, e);
        rw = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            if (i >= 1) begin
                if ((i % 4) == 3) begin
                    tests++; if (done2 !== 1'b1 || rd2 !== vals[(i + 1) / 4]) begin
                        fails++; $display("FAIL b2b_done cycle %0d got done %b data %h exp 1 %h",
                                          i, done2, rd2, vals[(i + 1) / 4]);
                    end
                end else if (done2 !== 1'b0) begin
                    tests++; fails++;
                    $display("FAIL b2b_nodone cycle %0d got 1 exp 0", i);
                end
            end
            addr = 16'(1 + (i + 3) / 4);
            sel2 = (i <= 8);
            @(negedge clk);
        end
        sel2 = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_write_read;
        test_zero_wait;
        test_addr_error;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
